// File: rtl/cpu_decode.sv
// cpu_decode: RV32I decode stage; issues on fetch tag change, inserts a load-use bubble, back-pressures fetch.
// Ports: i_clock, i_reset (sync, active-high); i_stall from execute; o_stall to fetch;
//   i_fetch_tag/i_fetch_instruction/i_fetch_pc from fetch; o_* registered decode fields for execute.
// Option: define CPU_DECODE_RVM_EN to decode M-extension ops and add the o_is_muldiv port.
module cpu_decode #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  output logic                 o_stall,
  input  logic [TAG_WIDTH-1:0] i_fetch_tag,
  input  logic [31:0]          i_fetch_instruction,
  input  logic [31:0]          i_fetch_pc,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_pc,
  output logic [31:0]          o_instruction,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [4:0]           o_rd,
  output logic [31:0]          o_imm,
  output logic [3:0]           o_alu_op,
  output logic                 o_is_alu,
  output logic                 o_is_load,
  output logic                 o_is_store,
  output logic                 o_is_branch,
  output logic                 o_is_jump,
  output logic                 o_is_lui,
  output logic                 o_is_auipc,
  output logic                 o_is_system,
  output logic                 o_is_illegal,
`ifdef CPU_DECODE_RVM_EN
  output logic                 o_is_muldiv,
`endif
  output logic                 o_reg_write
);
  logic [31:0] w_ins;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_branch, w_load, w_store;
  logic        w_op_imm, w_op_reg, w_system, w_md_word, w_alu_reg, w_muldiv;
  logic        w_is_alu, w_illegal;
  logic        w_fmt_r, w_fmt_i, w_fmt_s, w_fmt_b, w_fmt_u, w_fmt_j;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;
  logic [8:0]  w_class;
  logic        w_new, w_hazard;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [31:0] r_pc, r_instruction, r_imm;
  logic [4:0]  r_rs1, r_rs2, r_rd, r_load_rd;
  logic [3:0]  r_alu_op;
  logic [8:0]  r_class;
  logic        r_reg_write, r_load_pending;
  assign w_ins    = i_fetch_instruction;
  assign w_opcode = w_ins[6:0];
  assign w_funct3 = w_ins[14:12];
  assign w_funct7 = w_ins[31:25];
  // Full 7-bit opcode matches, so words with opcode[1:0] != 2'b11 fall out as illegal.
  assign w_lui     = w_opcode == 7'b0110111;
  assign w_auipc   = w_opcode == 7'b0010111;
  assign w_jal     = w_opcode == 7'b1101111;
  assign w_jalr    = w_opcode == 7'b1100111;
  assign w_branch  = w_opcode == 7'b1100011;
  assign w_load    = w_opcode == 7'b0000011;
  assign w_store   = w_opcode == 7'b0100011;
  assign w_op_imm  = w_opcode == 7'b0010011;
  assign w_op_reg  = w_opcode == 7'b0110011;
  assign w_system  = w_opcode == 7'b1110011;
  assign w_md_word = w_op_reg & (w_funct7 == 7'b0000001);
`ifdef CPU_DECODE_RVM_EN
  assign w_muldiv  = w_md_word;
  assign w_alu_reg = w_op_reg;
`else
  assign w_muldiv  = 1'b0;
  assign w_alu_reg = w_op_reg & ~w_md_word;
`endif
  assign w_is_alu  = w_op_imm | w_alu_reg;
  assign w_illegal = ~(w_lui | w_auipc | w_jal | w_jalr | w_branch | w_load | w_store |
                       w_is_alu | w_system);
  assign w_fmt_r = w_alu_reg;
  assign w_fmt_i = w_op_imm | w_load | w_jalr | w_system;
  assign w_fmt_s = w_store;
  assign w_fmt_b = w_branch;
  assign w_fmt_u = w_lui | w_auipc;
  assign w_fmt_j = w_jal;
  // Fields absent from the format read as 0 so they can never match a pending load rd.
  assign w_rd  = (w_fmt_r | w_fmt_i | w_fmt_u | w_fmt_j) ? w_ins[11:7] : 5'd0;
  assign w_rs1 = (w_fmt_r | w_fmt_i | w_fmt_s | w_fmt_b) ? w_ins[19:15] : 5'd0;
  assign w_rs2 = (w_fmt_r | w_fmt_s | w_fmt_b) ? w_ins[24:20] : 5'd0;
  assign w_imm = w_fmt_i ? {{20{w_ins[31]}}, w_ins[31:20]} :
                 w_fmt_s ? {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]} :
                 w_fmt_b ? {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0} :
                 w_fmt_u ? {w_ins[31:12], 12'd0} :
                 w_fmt_j ? {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0} :
                 32'd0;
  assign w_alu_op = w_muldiv ? {1'b1, w_funct3} :
                    w_is_alu ? {w_ins[30], w_funct3} : 4'd0;
  assign w_class  = {w_is_alu, w_load, w_store, w_branch, w_jal | w_jalr, w_lui, w_auipc,
                     w_system, w_illegal};
  // o_tag doubles as the last-seen fetch tag: both reset to 0 and change only on issue.
  assign w_new    = i_fetch_tag != r_tag;
  assign w_hazard = r_load_pending & (r_load_rd != 5'd0) &
                    ((w_rs1 == r_load_rd) | (w_rs2 == r_load_rd));
  assign o_stall  = i_stall | (w_new & w_hazard);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag          <= '0;
      r_pc           <= '0;
      r_instruction  <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_imm          <= '0;
      r_alu_op       <= '0;
      r_class        <= '0;
      r_reg_write    <= 1'b0;
      r_load_pending <= 1'b0;
      r_load_rd      <= '0;
    end else if (w_new & ~i_stall) begin
      if (w_hazard) begin
        r_load_pending <= 1'b0;
      end else begin
        r_tag          <= i_fetch_tag;
        r_pc           <= i_fetch_pc;
        r_instruction  <= w_ins;
        r_rs1          <= w_rs1;
        r_rs2          <= w_rs2;
        r_rd           <= w_rd;
        r_imm          <= w_imm;
        r_alu_op       <= w_alu_op;
        r_class        <= w_class;
        r_reg_write    <= ~w_illegal & (w_rd != 5'd0);
        r_load_pending <= w_load;
        r_load_rd      <= w_load ? w_rd : r_load_rd;
      end
    end
  end
`ifdef CPU_DECODE_RVM_EN
  logic r_is_muldiv;
  always_ff @(posedge i_clock) begin
    if (i_reset) r_is_muldiv <= 1'b0;
    else if (w_new & ~i_stall & ~w_hazard) r_is_muldiv <= w_muldiv;
  end
  assign o_is_muldiv = r_is_muldiv;
`endif
  assign o_tag         = r_tag;
  assign o_pc          = r_pc;
  assign o_instruction = r_instruction;
  assign o_rs1         = r_rs1;
  assign o_rs2         = r_rs2;
  assign o_rd          = r_rd;
  assign o_imm         = r_imm;
  assign o_alu_op      = r_alu_op;
  assign o_reg_write   = r_reg_write;
  assign {o_is_alu, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_lui, o_is_auipc,
          o_is_system, o_is_illegal} = r_class;
endmodule

// File: tb/tb_cpu_decode.sv
// tb_cpu_decode: scoreboard bench for cpu_decode driven by a fetch-stage model.
module tb_cpu_decode;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stall = 1'b0;
  logic [7:0]  i_fetch_tag = 8'd0;
  logic [31:0] i_fetch_instruction = 32'd0;
  logic [31:0] i_fetch_pc = 32'd0;
  logic        o_stall;
  logic [7:0]  o_tag;
  logic [31:0] o_pc, o_instruction, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_alu_op;
  logic        o_is_alu, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_lui;
  logic        o_is_auipc, o_is_system, o_is_illegal, o_reg_write;
  logic        o_is_muldiv;
  cpu_decode #(.TAG_WIDTH(8)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .o_stall(o_stall),
    .i_fetch_tag(i_fetch_tag), .i_fetch_instruction(i_fetch_instruction),
    .i_fetch_pc(i_fetch_pc), .o_tag(o_tag), .o_pc(o_pc), .o_instruction(o_instruction),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm), .o_alu_op(o_alu_op),
    .o_is_alu(o_is_alu), .o_is_load(o_is_load), .o_is_store(o_is_store),
    .o_is_branch(o_is_branch), .o_is_jump(o_is_jump), .o_is_lui(o_is_lui),
    .o_is_auipc(o_is_auipc), .o_is_system(o_is_system), .o_is_illegal(o_is_illegal),
`ifdef CPU_DECODE_RVM_EN
    .o_is_muldiv(o_is_muldiv),
`endif
    .o_reg_write(o_reg_write)
  );
`ifndef CPU_DECODE_RVM_EN
  assign o_is_muldiv = 1'b0;
`endif
  always #5 i_clock = ~i_clock;
  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;
  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        alu_c, load, store, branch, jump, lui, auipc, system, illegal, rw, md;
  } dec_t;
  typedef struct {
    logic [7:0]  tag;
    logic [31:0] pc, ins;
    dec_t        d;
    int          cyc;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic       mon_en = 1'b0;
  logic [7:0] last_o_tag = 8'd0;
  logic       pl_valid = 1'b0;
  logic [4:0] pl_rd = 5'd0;
  logic [7:0] next_tag = 8'd1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    return 32'($signed(v << (32 - n)) >>> (32 - n));
  endfunction
  // Reference decode written directly from the instruction-set tables.
  function automatic dec_t ref_dec(input logic [31:0] w);
    dec_t d;
    d = '0;
    case (w[6:0])
      7'h37: begin d.lui = 1; d.rd = w[11:7]; d.imm = w & 32'hFFFFF000; end
      7'h17: begin d.auipc = 1; d.rd = w[11:7]; d.imm = w & 32'hFFFFF000; end
      7'h6f: begin
        d.jump = 1; d.rd = w[11:7];
        d.imm = sext({w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      end
      7'h67: begin d.jump = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.imm = sext(w >> 20, 12); end
      7'h63: begin
        d.branch = 1; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = sext({w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
      end
      7'h03: begin d.load = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.imm = sext(w >> 20, 12); end
      7'h23: begin
        d.store = 1; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        d.imm = sext({w[31:25], w[11:7]}, 12);
      end
      7'h13: begin
        d.alu_c = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.imm = sext(w >> 20, 12);
        d.alu = {w[30], w[14:12]};
      end
      7'h33: begin
        if (w[31:25] == 7'd1) begin
`ifdef CPU_DECODE_RVM_EN
          d.alu_c = 1; d.md = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
          d.alu = {1'b1, w[14:12]};
`else
          d.illegal = 1;
`endif
        end else begin
          d.alu_c = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
          d.alu = {w[30], w[14:12]};
        end
      end
      7'h73: begin d.system = 1; d.rd = w[11:7]; d.rs1 = w[19:15]; d.imm = sext(w >> 20, 12); end
      default: d.illegal = 1;
    endcase
    d.rw = !d.illegal && d.rd != 5'd0;
    return d;
  endfunction
  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    w = $urandom;
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 12))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6f;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5, 11: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;
      9: w[6:0] = 7'h73;
      10: begin w[6:0] = 7'h33; w[31:25] = $urandom_range(0, 1) ? 7'h01 : 7'h20; end
      default: ;
    endcase
    return w;
  endfunction
  // Fetch model: present one new instruction and hold it until decode accepts it.
  task automatic issue(input logic [31:0] ins, input int nstall, input int prob);
    dec_t d;
    exp_t e;
    logic bubble;
    bit   done;
    int   k;
    d = ref_dec(ins);
    bubble = pl_valid && (d.rs1 == pl_rd || d.rs2 == pl_rd);
    i_fetch_tag = next_tag;
    i_fetch_instruction = ins;
    i_fetch_pc = $urandom & 32'hFFFF_FFFC;
    done = 0;
    k = 0;
    while (!done) begin
      i_stall = (k < nstall) || ($urandom_range(0, 99) < prob);
      k++;
      @(negedge i_clock);
      chk("o_stall", o_stall, i_stall | bubble);
      if (!i_stall) begin
        if (bubble) begin
          bubble = 0;
          pl_valid = 0;
        end else begin
          e.tag = i_fetch_tag; e.pc = i_fetch_pc; e.ins = ins; e.d = d; e.cyc = cyc + 1;
          q.push_back(e);
          pl_valid = d.load && d.rd != 5'd0;
          pl_rd = d.rd;
          done = 1;
        end
      end
      @(posedge i_clock); #1;
    end
    next_tag++;
  endtask
  task automatic idle(input int n, input int prob);
    repeat (n) begin
      i_stall = $urandom_range(0, 99) < prob;
      @(negedge i_clock);
      chk("o_stall_idle", o_stall, i_stall);
      @(posedge i_clock); #1;
    end
  endtask
  task automatic peek_begin();
    @(negedge i_clock);
  endtask
  task automatic peek_end();
    @(posedge i_clock); #1;
  endtask
  task automatic reset_dut();
    mon_en = 0;
    i_reset = 1;
    @(posedge i_clock); #1;
    i_reset = 0;
    i_stall = 0;
    i_fetch_tag = 8'd0;
    pl_valid = 0;
    next_tag = 8'd1;
    @(negedge i_clock);
    chk("rst_tag", o_tag, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_ins", o_instruction, 0);
    chk("rst_regs", {o_rs1, o_rs2, o_rd}, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_class", {o_is_alu, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_lui,
                      o_is_auipc, o_is_system, o_is_illegal, o_is_muldiv}, 0);
    chk("rst_reg_write", o_reg_write, 0);
    chk("rst_stall", o_stall, 0);
    last_o_tag = 8'd0;
    mon_en = 1;
    @(posedge i_clock); #1;
  endtask
  // Monitor: every change of o_tag is one issue and must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clock);
      if (mon_en && o_tag !== last_o_tag) begin
        last_o_tag = o_tag;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_issue: o_tag=%0h with nothing expected", o_tag);
        end else begin
          e = q.pop_front();
          chk("tag", o_tag, e.tag);
          chk("issue_cycle", cyc, e.cyc);
          chk("pc", o_pc, e.pc);
          chk("instruction", o_instruction, e.ins);
          chk("rs1", o_rs1, e.d.rs1);
          chk("rs2", o_rs2, e.d.rs2);
          chk("rd", o_rd, e.d.rd);
          chk("imm", o_imm, e.d.imm);
          chk("alu_op", o_alu_op, e.d.alu);
          chk("class", {o_is_alu, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_lui,
                        o_is_auipc, o_is_system, o_is_illegal},
                       {e.d.alu_c, e.d.load, e.d.store, e.d.branch, e.d.jump, e.d.lui,
                        e.d.auipc, e.d.system, e.d.illegal});
          chk("reg_write", o_reg_write, e.d.rw);
          chk("muldiv", o_is_muldiv, e.d.md);
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    reset_dut();
    issue(32'h00510093, 0, 0);
    peek_begin();
    chk("addi_tag", o_tag, 1);
    chk("addi_rd", o_rd, 1);
    chk("addi_rs1", o_rs1, 2);
    chk("addi_imm", o_imm, 5);
    chk("addi_alu", o_is_alu, 1);
    chk("addi_reg_write", o_reg_write, 1);
    chk("addi_stall", o_stall, 0);
    peek_end();
    issue(32'h0000A183, 0, 0);
    issue(32'h00518233, 0, 0);
    peek_begin();
    chk("add_tag", o_tag, 3);
    chk("add_rs1", o_rs1, 3);
    chk("add_rs2", o_rs2, 5);
    peek_end();
    issue(32'h00108113, 3, 0);
    peek_begin();
    chk("stall_release_tag", o_tag, 4);
    peek_end();
    issue(32'h00000463, 0, 0);
    idle(10, 0);
    peek_begin();
    chk("beq_tag_held", o_tag, 5);
    chk("beq_branch", o_is_branch, 1);
    chk("beq_imm", o_imm, 8);
    chk("beq_reg_write", o_reg_write, 0);
    peek_end();
    next_tag = 8'd255;
    issue(32'h00510093, 0, 0);
    issue(32'h00000000, 0, 0);
    peek_begin();
    chk("wrap_tag", o_tag, 0);
    chk("wrap_illegal", o_is_illegal, 1);
    chk("wrap_reg_write", o_reg_write, 0);
    peek_end();
    issue(32'h02208033, 0, 0);
    peek_begin();
`ifdef CPU_DECODE_RVM_EN
    chk("mul_muldiv", o_is_muldiv, 1);
    chk("mul_alu_op", o_alu_op, 8);
    chk("mul_reg_write", o_reg_write, 0);
`else
    chk("mul_illegal", o_is_illegal, 1);
    chk("mul_alu", o_is_alu, 0);
`endif
    peek_end();
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 30);
      issue(gen_ins(), 0, 25);
    end
    issue(32'h0000A183, 0, 0);
    i_fetch_tag = next_tag;
    i_fetch_instruction = 32'h00518233;
    i_stall = 0;
    @(negedge i_clock);
    chk("bubble_before_reset", o_stall, 1);
    i_stall = 1;
    reset_dut();
    issue(32'h00518233, 0, 0);
    idle(3, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_decode.md
Name: cpu_decode

Overview:
Decode stage sitting directly downstream of the fetch stage. It consumes the fetch stage's tag/instruction/pc triple and detects each new instruction by a change of tag. It registers the decoded fields (register indices, sign-extended immediate, operation class, ALU op) for the execute stage. It back-pressures fetch through o_stall and inserts a one-cycle bubble on a load-use hazard.

Parameters:
TAG_WIDTH, 8, width of the fetch/decode tag; must match the fetch stage tag width.

Ports:
i_clock  in  1  clock, all state on rising edge
i_reset  in  1  synchronous reset, active-high
i_stall  in  1  execute stage cannot accept a new decoded instruction this cycle
o_stall  out  1  to fetch i_stall; fetch must hold its outputs and not advance
i_fetch_tag  in  TAG_WIDTH  fetch output tag; a change means a new instruction
i_fetch_instruction  in  32  raw instruction word
i_fetch_pc  in  32  pc of that instruction
o_tag  out  TAG_WIDTH  tag of the decoded instruction; a change means a new issue to execute
o_pc  out  32  pc of the decoded instruction
o_instruction  out  32  raw word, passed through
o_rs1, o_rs2, o_rd  out  5 each  register indices; 0 when the format lacks the field
o_imm  out  32  sign-extended immediate (I/S/B/U/J); 0 for R-type
o_alu_op  out  4  ALU operation code: {funct7[5], funct3} for OP/OP-IMM; 0 (add) otherwise
o_is_alu, o_is_load, o_is_store, o_is_branch, o_is_jump, o_is_lui, o_is_auipc, o_is_system, o_is_illegal  out  1 each  one-hot operation class
o_reg_write  out  1  instruction writes rd and rd != 0

Behaviour:
- Reset, synchronous: every output is 0; internal last_tag = 0, load_pending = 0, load_rd = 0. Fetch also resets its tag to 0, so no instruction is seen after reset.
- New instruction: new = (i_fetch_tag != last_tag). Comparison is by inequality only, so tag wrap 255->0 is a normal change.
- Hazard: if load_pending, load_rd != 0, and new rs1 or rs2 == load_rd, then hazard = 1. rs2 is considered only for R/S/B formats.
- o_stall (combinational) = i_stall | (new & hazard).
- Issue, on the edge where new & !i_stall & !hazard:
  - all decoded outputs are registered from the fetch inputs;
  - o_tag <= i_fetch_tag; last_tag <= i_fetch_tag.
  - Latency is 1 cycle from the fetch tag change to the o_tag change.
- Bubble, on the edge where new & !i_stall & hazard:
  - outputs are held, tag unchanged;
  - load_pending <= 0;
  - the instruction issues on the next edge if i_stall is still low.
  - Exactly one bubble per load-use pair.
- load_pending <= 1 and load_rd <= rd on issue of a load. On any other issue, load_pending <= 0.
- When i_stall = 1, all registers hold, including load_pending.
- Without new: outputs hold; o_tag is unchanged, so execute does not re-execute.
- Branch interplay: fetch stops after a branch until the branch result arrives. Decode simply sees no tag change; no special state is needed.
- Illegal instruction:
  - covers an unrecognised opcode, or opcode[1:0] != 2'b11;
  - issues normally with o_is_illegal = 1, all other class flags 0, o_reg_write = 0.
- Reset asserted mid-stall or mid-bubble: cleared next edge, no pending issue survives.

Optional Feature:
CPU_DECODE_RVM_EN: when defined, OP with funct7 = 0000001 decodes as an M-extension op: o_is_alu = 1, o_alu_op = {1'b1, funct3}, extra output o_is_muldiv = 1. When undefined, such words set o_is_illegal and the o_is_muldiv port is absent.

Test Plan:
- Reset, then fetch tag 0->1 with 0x00510093 (addi x1,x2,5), i_stall = 0 -> next cycle: o_tag = 1, o_rd = 1, o_rs1 = 2, o_imm = 5, o_is_alu = 1, o_reg_write = 1, o_stall = 0.
- Tag 1->2 with 0x0000A183 (lw x3,0(x1)), then tag 3 with 0x00518233 (add x4,x3,x5) -> o_stall = 1 for exactly one cycle, o_tag stays 2, then o_tag = 3 with o_rs1 = 3, o_rs2 = 5.
- i_stall = 1 for 3 cycles while tag 4 is presented -> outputs and o_tag frozen, o_stall = 1; release -> o_tag = 4 one cycle later.
- Tag 5 with 0x00000463 (beq x0,x0,8) -> o_is_branch = 1, o_imm = 8, o_reg_write = 0. Tag held 10 cycles -> o_tag stays 5.
- Tag 255->0 with 0x00000000 -> issues: o_tag = 0, o_is_illegal = 1. Wrap detected.
- 0x02208033 (mul x0,x1,x2): with CPU_DECODE_RVM_EN -> o_is_muldiv = 1, o_alu_op = 8, o_reg_write = 0. Without the macro -> o_is_illegal = 1.
